// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 16-bit five-stage core.
// Watches ID/EX/MEM and drives PC and pipeline-register stall/flush controls
// for load-use interlock, mispredict redirect and data-memory wait, and keeps
// saturating performance counters plus a sticky memory-timeout flag.
//
// Ports:
//   i_clk, i_rst                 core clock, synchronous active-high reset
//   i_id_p0_addr/i_id_p1_addr    ID source registers, i_id_p0_used/i_id_p1_used
//   i_ex_mem_re, i_ex_we         EX instruction is a load / writes the reg file
//   i_ex_dst_addr                EX destination register
//   i_ex_mispredict              branch resolved in EX disagrees with prediction
//   i_mem_busy                   MEM data access not complete this cycle
//   o_pc_hold, o_pc_redirect     PC controls
//   o_stall_*, o_flush_*         pipeline register controls
//   o_state                      RUN=0 LDUSE=1 MEMWAIT=2 REDIR=3
//   o_mem_err                    sticky memory-timeout flag
//   o_stall_cycles, o_flush_count saturating performance counters
//
// state   | meaning
// RUN     | normal flow, no hazard in the previous cycle
// LDUSE   | one load-use bubble was inserted last cycle
// MEMWAIT | pipeline was held for a busy data memory last cycle
// REDIR   | second mispredict cycle: squash wrong-path fetch word
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_id_p0_addr,
  input  logic [3:0]  i_id_p1_addr,
  input  logic        i_id_p0_used,
  input  logic        i_id_p1_used,
  input  logic        i_ex_mem_re,
  input  logic        i_ex_we,
  input  logic [3:0]  i_ex_dst_addr,
  input  logic        i_ex_mispredict,
  input  logic        i_mem_busy,
  output logic        o_pc_hold,
  output logic        o_pc_redirect,
  output logic        o_stall_if_id,
  output logic        o_stall_id_ex,
  output logic        o_stall_ex_mem,
  output logic        o_flush_if_id,
  output logic        o_flush_id_ex,
  output logic        o_stall_mem_wb,
  output logic [1:0]  o_state,
  output logic        o_mem_err,
  output logic [15:0] o_stall_cycles,
  output logic [7:0]  o_flush_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDUSE   = 2'd1,
    MEMWAIT = 2'd2,
    REDIR   = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_wait_cnt;
  logic        r_mem_err;
  logic [15:0] r_stall_cycles;
  logic [7:0]  r_flush_count;
  logic        w_load_use;

  // R0 is hardwired zero, so a load targeting it never creates a dependency.
  assign w_load_use = i_ex_mem_re & i_ex_we & (i_ex_dst_addr != 4'd0) &
                      ((i_id_p0_used & (i_id_p0_addr == i_ex_dst_addr)) |
                       (i_id_p1_used & (i_id_p1_addr == i_ex_dst_addr)));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= RUN;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = RUN;
    if (i_mem_busy)                w_next_state = MEMWAIT;
    else if (r_state == REDIR)     w_next_state = RUN;
    else if (i_ex_mispredict)      w_next_state = REDIR;
    else if (w_load_use)           w_next_state = LDUSE;
  end

  // REDIR keeps squashing IF/ID even under a memory stall; mispredict and
  // load-use are only looked at once the memory is idle since EX is held.
  always_comb begin
    o_pc_hold      = 1'b0;
    o_pc_redirect  = 1'b0;
    o_stall_if_id  = 1'b0;
    o_stall_id_ex  = 1'b0;
    o_stall_ex_mem = 1'b0;
    o_flush_if_id  = 1'b0;
    o_flush_id_ex  = 1'b0;
    o_stall_mem_wb = 1'b0;
    if (!i_rst) begin
      if (i_mem_busy) begin
        o_pc_hold      = 1'b1;
        o_stall_if_id  = 1'b1;
        o_stall_id_ex  = 1'b1;
        o_stall_ex_mem = 1'b1;
        o_stall_mem_wb = 1'b1;
        o_flush_if_id  = (r_state == REDIR);
      end else if (r_state == REDIR) begin
        o_flush_if_id  = 1'b1;
      end else if (i_ex_mispredict) begin
        o_pc_redirect  = 1'b1;
        o_flush_if_id  = 1'b1;
        o_flush_id_ex  = 1'b1;
      end else if (w_load_use) begin
        o_pc_hold      = 1'b1;
        o_stall_if_id  = 1'b1;
        o_flush_id_ex  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt     <= 8'd0;
      r_mem_err      <= 1'b0;
      r_stall_cycles <= 16'd0;
      r_flush_count  <= 8'd0;
    end else begin
      if (!i_mem_busy)               r_wait_cnt <= 8'd0;
      else if (r_wait_cnt != TO_LAST) r_wait_cnt <= r_wait_cnt + 8'd1;
      if (i_mem_busy && (r_wait_cnt == TO_LAST)) r_mem_err <= 1'b1;
      if (o_pc_hold && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
      if (o_pc_redirect && (r_flush_count != 8'hFF))
        r_flush_count <= r_flush_count + 8'd1;
    end
  end

  assign o_state        = r_state;
  assign o_mem_err      = r_mem_err;
  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl. Two instances share all
// inputs: dut_a uses the default memory timeout, dut_b uses MEM_TIMEOUT=4.
// Each driven cycle pushes its expected response; a negedge monitor pops and
// compares.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [3:0] p0, p1;
    logic       u0, u1, mre, we;
    logic [3:0] dst;
    logic       mp, busy;
  } stim_t;

  typedef struct {
    logic [7:0]  ctrl;
    logic        chk_st;
    logic [1:0]  st;
    logic        chk_cnt;
    logic [15:0] sc;
    logic [7:0]  fc;
    logic        ea, eb;
  } exp_t;

  // ctrl = {pc_hold, pc_redirect, stall_if_id, stall_id_ex, stall_ex_mem,
  //         stall_mem_wb, flush_if_id, flush_id_ex}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b1010_0001;
  localparam logic [7:0] C_MEM  = 8'b1011_1100;
  localparam logic [7:0] C_MP   = 8'b0100_0011;
  localparam logic [7:0] C_RD   = 8'b0000_0010;
  localparam logic [7:0] C_RDM  = 8'b1011_1110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, p0_used, p1_used, ex_mem_re, ex_we, ex_mp, mem_busy;
  logic [3:0] p0_addr, p1_addr, ex_dst;

  logic        a_pc_hold, a_pc_redirect, a_s_ifid, a_s_idex, a_s_exmem;
  logic        a_f_ifid, a_f_idex, a_s_memwb, a_mem_err;
  logic [1:0]  a_state;
  logic [15:0] a_sc;
  logic [7:0]  a_fc;
  logic        b_pc_hold, b_pc_redirect, b_s_ifid, b_s_idex, b_s_exmem;
  logic        b_f_ifid, b_f_idex, b_s_memwb, b_mem_err;
  logic [1:0]  b_state;
  logic [15:0] b_sc;
  logic [7:0]  b_fc;

  hazard_ctrl dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_id_p0_addr(p0_addr), .i_id_p1_addr(p1_addr),
    .i_id_p0_used(p0_used), .i_id_p1_used(p1_used),
    .i_ex_mem_re(ex_mem_re), .i_ex_we(ex_we), .i_ex_dst_addr(ex_dst),
    .i_ex_mispredict(ex_mp), .i_mem_busy(mem_busy),
    .o_pc_hold(a_pc_hold), .o_pc_redirect(a_pc_redirect),
    .o_stall_if_id(a_s_ifid), .o_stall_id_ex(a_s_idex),
    .o_stall_ex_mem(a_s_exmem), .o_flush_if_id(a_f_ifid),
    .o_flush_id_ex(a_f_idex), .o_stall_mem_wb(a_s_memwb),
    .o_state(a_state), .o_mem_err(a_mem_err),
    .o_stall_cycles(a_sc), .o_flush_count(a_fc)
  );

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_id_p0_addr(p0_addr), .i_id_p1_addr(p1_addr),
    .i_id_p0_used(p0_used), .i_id_p1_used(p1_used),
    .i_ex_mem_re(ex_mem_re), .i_ex_we(ex_we), .i_ex_dst_addr(ex_dst),
    .i_ex_mispredict(ex_mp), .i_mem_busy(mem_busy),
    .o_pc_hold(b_pc_hold), .o_pc_redirect(b_pc_redirect),
    .o_stall_if_id(b_s_ifid), .o_stall_id_ex(b_s_idex),
    .o_stall_ex_mem(b_s_exmem), .o_flush_if_id(b_f_ifid),
    .o_flush_id_ex(b_f_idex), .o_stall_mem_wb(b_s_memwb),
    .o_state(b_state), .o_mem_err(b_mem_err),
    .o_stall_cycles(b_sc), .o_flush_count(b_fc)
  );

  exp_t  q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_items  = 0;
  stim_t s;
  exp_t  e;

  task automatic chk(input string name, input int item, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s item %0d: got %0h expected %0h", name, item, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("ctrl", n_items, {a_pc_hold, a_pc_redirect, a_s_ifid, a_s_idex,
                            a_s_exmem, a_s_memwb, a_f_ifid, a_f_idex}, x.ctrl);
      if (x.chk_st) chk("state", n_items, a_state, x.st);
      if (x.chk_cnt) begin
        chk("stall_cycles", n_items, a_sc, x.sc);
        chk("flush_count", n_items, a_fc, x.fc);
        chk("mem_err", n_items, a_mem_err, x.ea);
        chk("mem_err_to4", n_items, b_mem_err, x.eb);
      end
      n_items++;
    end
  end

  task automatic apply();
    rst = s.rst; p0_addr = s.p0; p1_addr = s.p1; p0_used = s.u0; p1_used = s.u1;
    ex_mem_re = s.mre; ex_we = s.we; ex_dst = s.dst; ex_mp = s.mp; mem_busy = s.busy;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    apply();
    q.push_back(e);
  endtask

  task automatic idle();
    s = '0;
  endtask

  task automatic ldu(input logic [3:0] dst, input logic [3:0] a0, input logic u0,
                     input logic [3:0] a1, input logic u1, input logic mre);
    s = '0; s.mre = mre; s.we = 1'b1; s.dst = dst;
    s.p0 = a0; s.u0 = u0; s.p1 = a1; s.u1 = u1;
  endtask

  task automatic ex(input logic [7:0] c, input logic [1:0] st);
    e.ctrl = c; e.chk_st = 1'b1; e.st = st; e.chk_cnt = 1'b0;
    e.sc = '0; e.fc = '0; e.ea = 1'b0; e.eb = 1'b0;
  endtask

  task automatic cnt(input int sc, input int fc, input logic ea, input logic eb);
    e.chk_cnt = 1'b1; e.sc = 16'(sc); e.fc = 8'(fc); e.ea = ea; e.eb = eb;
  endtask

  initial begin
    s = '0; s.rst = 1'b1; apply();
    @(posedge clk); #1;
    // reset held: outputs inactive, registers cleared
    s.rst = 1'b1; s.mp = 1'b1; ex(C_NONE, 2'd0); cnt(0, 0, 0, 0); cyc();

    // load-use on p0: ld r3 in EX, add r4,r3,r5 in ID
    ldu(4'd3, 4'd3, 1'b1, 4'd5, 1'b1, 1'b1); ex(C_LU, 2'd0); cnt(0, 0, 0, 0); cyc();
    idle(); ex(C_NONE, 2'd1); cnt(1, 0, 0, 0); cyc();
    idle(); ex(C_NONE, 2'd0); cyc();
    // dst=r0: no hazard
    ldu(4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1); ex(C_NONE, 2'd0); cyc();
    // p1 matches but unused: no hazard
    ldu(4'd5, 4'd2, 1'b1, 4'd5, 1'b0, 1'b1); ex(C_NONE, 2'd0); cyc();
    // match but EX is not a load
    ldu(4'd4, 4'd4, 1'b1, 4'd6, 1'b1, 1'b0); ex(C_NONE, 2'd0); cyc();
    // load-use on p1
    ldu(4'd5, 4'd2, 1'b1, 4'd5, 1'b1, 1'b1); ex(C_LU, 2'd0); cnt(1, 0, 0, 0); cyc();
    idle(); ex(C_NONE, 2'd1); cnt(2, 0, 0, 0); cyc();
    idle(); ex(C_NONE, 2'd0); cyc();

    // single mispredict; load-use pattern in REDIR must be ignored
    idle(); s.mp = 1'b1; ex(C_MP, 2'd0); cnt(2, 0, 0, 0); cyc();
    ldu(4'd3, 4'd3, 1'b1, 4'd5, 1'b1, 1'b1); ex(C_RD, 2'd3); cyc();
    idle(); ex(C_NONE, 2'd0); cnt(2, 1, 0, 0); cyc();

    // mem_busy for 5 cycles; the timeout-4 instance flags at its 4th busy edge
    for (int i = 1; i <= 5; i++) begin
      idle(); s.busy = 1'b1; ex(C_MEM, (i == 1) ? 2'd0 : 2'd2);
      cnt(2 + i - 1, 1, 1'b0, (i >= 5)); cyc();
    end
    idle(); ex(C_NONE, 2'd2); cnt(7, 1, 0, 1); cyc();
    idle(); ex(C_NONE, 2'd0); cyc();

    // mem_busy and mispredict together for 3 cycles, then redirect
    for (int i = 1; i <= 3; i++) begin
      idle(); s.busy = 1'b1; s.mp = 1'b1; ex(C_MEM, (i == 1) ? 2'd0 : 2'd2); cyc();
    end
    idle(); s.mp = 1'b1; ex(C_MP, 2'd2); cnt(10, 1, 0, 1); cyc();
    idle(); ex(C_RD, 2'd3); cyc();
    idle(); ex(C_NONE, 2'd0); cnt(10, 2, 0, 1); cyc();

    // mem_busy arriving in REDIR
    idle(); s.mp = 1'b1; ex(C_MP, 2'd0); cyc();
    idle(); s.busy = 1'b1; ex(C_RDM, 2'd3); cyc();
    idle(); ex(C_NONE, 2'd2); cyc();
    idle(); ex(C_NONE, 2'd0); cnt(11, 3, 0, 1); cyc();

    // reset mid-MEMWAIT
    idle(); s.busy = 1'b1; ex(C_MEM, 2'd0); cyc();
    idle(); s.busy = 1'b1; ex(C_MEM, 2'd2); cyc();
    idle(); s.rst = 1'b1; s.busy = 1'b1; s.mp = 1'b1; ex(C_NONE, 2'd0); e.chk_st = 1'b0; cyc();
    idle(); ex(C_NONE, 2'd0); cnt(0, 0, 0, 0); cyc();

    // 10 busy cycles: timeout-4 flag rises after the 4th edge and sticks
    for (int i = 1; i <= 10; i++) begin
      idle(); s.busy = 1'b1; ex(C_MEM, (i == 1) ? 2'd0 : 2'd2);
      cnt(i - 1, 0, 1'b0, (i >= 5)); cyc();
    end
    idle(); ex(C_NONE, 2'd2); cnt(10, 0, 0, 1); cyc();
    idle(); ex(C_NONE, 2'd0); cnt(10, 0, 0, 1); cyc();
    idle(); s.rst = 1'b1; ex(C_NONE, 2'd0); e.chk_st = 1'b0; cyc();
    idle(); ex(C_NONE, 2'd0); cnt(0, 0, 0, 0); cyc();

    // 300 mispredicts: flush_count saturates at 255
    for (int i = 0; i < 300; i++) begin
      idle(); s.mp = 1'b1; ex(C_MP, 2'd0); cnt(0, (i < 255) ? i : 255, 0, 0); cyc();
      idle(); ex(C_RD, 2'd3); cyc();
    end
    idle(); ex(C_NONE, 2'd0); cnt(0, 255, 0, 0); cyc();

    begin
      int budget;
      budget = 0;
      while (q.size() > 0 && budget < 10) begin
        @(negedge clk); #1;
        budget++;
      end
      if (q.size() > 0) begin
        n_errors++;
        $display("FAIL drain: %0d expected responses never compared", q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 16-bit five-stage processor core. It watches the decode, execute and memory stages and drives the stall and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It handles three cases: load-use interlock, branch-mispredict redirect with a wrong-path squash, and multi-cycle data-memory wait with a timeout flag. It also keeps saturating performance counters.

## Interface
- MEM_TIMEOUT, 64: number of consecutive mem_busy cycles that sets mem_err (range 2..255).
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- id_p0_addr, id_p1_addr  in  4 each  source register addresses of the instruction in ID.
- id_p0_used, id_p1_used  in  1 each  the ID instruction reads p0 / p1.
- ex_mem_re  in  1  the instruction in EX is a load.
- ex_we  in  1  the instruction in EX writes the register file.
- ex_dst_addr  in  4  destination register of the instruction in EX.
- ex_mispredict  in  1  the branch resolved in EX disagrees with the fetch prediction.
- mem_busy  in  1  the data-memory access in MEM has not completed this cycle.
- pc_hold  out  1  PC keeps its value.
- pc_redirect  out  1  PC loads the corrected branch target.
- stall_if_id, stall_id_ex, stall_ex_mem  out  1 each  hold the register.
- flush_if_id, flush_id_ex  out  1 each  load a bubble.
- stall_mem_wb  out  1  MEM/WB loads a bubble (we=0).
- state  out  2  RUN=0, LDUSE=1, MEMWAIT=2, REDIR=3.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cycles  out  16  saturating count of cycles with pc_hold=1.
- flush_count  out  8  saturating count of mispredicts.

## Operation
- Control outputs are combinational from the registered state and the current inputs. state, the counters, mem_err and the internal wait counter are registered.
- R0 reads as constant zero, so ex_dst_addr==0 never creates a hazard.
- Load-use condition: ex_mem_re & ex_we & ex_dst_addr!=0 & ((id_p0_used & id_p0_addr==ex_dst_addr) | (id_p1_used & id_p1_addr==ex_dst_addr)).
- Evaluation priority each cycle is mem_busy, then ex_mispredict, then load-use.
- mem_busy=1, any state except REDIR-second-cycle effects:
  - Assert pc_hold, stall_if_id, stall_id_ex, stall_ex_mem and stall_mem_wb.
  - Next state is MEMWAIT.
  - Mispredict and load-use are ignored while mem_busy is high. EX is held, so they are re-evaluated once mem_busy drops.
- mem_busy=0 in RUN, MEMWAIT or LDUSE (evaluated as RUN):
  - Mispredict: assert pc_redirect, flush_if_id and flush_id_ex; next state REDIR; flush_count increments.
  - Else load-use: assert pc_hold, stall_if_id and flush_id_ex; next state LDUSE.
  - Else all outputs are inactive; next state RUN.
- REDIR lasts one cycle:
  - flush_if_id=1 squashes the wrong-path word from the synchronous instruction memory.
  - Load-use detection is suppressed, since ID holds a bubble.
  - Next state is RUN.
  - If mem_busy=1 in REDIR, the memory-stall outputs are asserted together with flush_if_id and the next state is MEMWAIT.
- Wait counter: 8 bits. It increments in every cycle where mem_busy=1 and clears when mem_busy=0.
  - When it reaches MEM_TIMEOUT-1 while mem_busy=1, mem_err sets and stays set until rst.
  - The stall continues; the counter saturates.
- stall_cycles and flush_count saturate at all-ones; they do not wrap.

## Timing
- While rst=1, all combinational control outputs are forced to 0.
- On the first rising clk edge with rst=1:
  - state=RUN, mem_err=0, stall_cycles=0, flush_count=0, wait counter=0.
  - This applies mid-stall and mid-redirect; no pending hazard survives reset.
- Output latency is zero cycles: controls are valid in the same cycle the hazard inputs are valid, and pipeline registers act on the next edge.
- A load-use hazard costs exactly one bubble.
  - In cycle T+1 the load has moved to MEM, so the condition clears and the pipeline advances.
- A mispredict costs two bubbles: cycle T flushes IF/ID and ID/EX; cycle T+1 (REDIR) flushes IF/ID.
- A memory wait of N busy cycles holds the pipeline N cycles. MEM/WB receives N bubbles.
- When mem_busy and ex_mispredict rise together, only the memory stall is applied. The redirect happens in the first cycle after mem_busy falls.

## Test plan
- Load-use, for example `ld r3` in EX with `add r4,r3,r5` in ID:
  - pc_hold=stall_if_id=flush_id_ex=1 for exactly 1 cycle; state 0→1→0; stall_cycles=1.
  - Repeat with dst=r0: no stall.
  - Repeat with id_p1_used=0 and a p1 match: no stall.
- Single mispredict pulse:
  - Cycle T: pc_redirect=flush_if_id=flush_id_ex=1.
  - Cycle T+1: flush_if_id=1 only, state=3.
  - Cycle T+2: state=0; flush_count=1.
- mem_busy high for 5 cycles:
  - All stalls and stall_mem_wb=1 for 5 cycles; state=2; stall_cycles=5; mem_err=0.
- mem_busy and ex_mispredict high together for 3 cycles, then mem_busy drops:
  - 3 stall cycles, then the redirect sequence; flush_count=1.
- MEM_TIMEOUT=4 with mem_busy held 10 cycles:
  - mem_err rises at the 4th busy cycle edge and stays 1 after mem_busy falls.
  - Clears only on rst.
- Counter saturation and reset:
  - Force 300 mispredicts: flush_count=255.
  - Assert rst mid-MEMWAIT: outputs 0 immediately; after the edge, state=0 and all counters 0.
